// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM command encodings and owner-state type for the two-client arbiter.
package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam int READ_BURST_LENGTH = 8;

    // Which client currently drives the controller.
    typedef enum logic {
        S_PROC = 1'b0,
        S_DISP = 1'b1
    } owner_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Client/controller-side bundle of the SDRAM arbiter.
// slave  : arbiter view (drives the o_* signals)
// master : surrounding logic view (drives the i_* signals)
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int LAT_WIDTH  = 8
);
    logic [1:0]            i_Proc_Command;
    logic [ADDR_WIDTH-1:0] i_Proc_Address;
    logic [DATA_WIDTH-1:0] i_Proc_Data_Write;
    logic                  i_Proc_SDRAM_Yield;
    logic                  o_Proc_SDRAM_Requested;
    logic                  o_Proc_Data_Read_Valid;
    logic                  o_Proc_Data_Write_Done;

    logic                  i_Disp_Request;
    logic [1:0]            i_Disp_Command;
    logic [ADDR_WIDTH-1:0] i_Disp_Address;
    logic                  o_Disp_Grant;
    logic                  o_Disp_Data_Read_Valid;

    logic [1:0]            o_Command;
    logic [ADDR_WIDTH-1:0] o_Data_Address;
    logic [DATA_WIDTH-1:0] o_Data_Write;
    logic                  i_Data_Read_Valid;
    logic                  i_Data_Write_Done;

    logic                  o_Yield_Timeout;
    logic [LAT_WIDTH-1:0]  o_Max_Yield_Latency;

    modport slave (
        input  i_Proc_Command, i_Proc_Address, i_Proc_Data_Write, i_Proc_SDRAM_Yield,
        output o_Proc_SDRAM_Requested, o_Proc_Data_Read_Valid, o_Proc_Data_Write_Done,
        input  i_Disp_Request, i_Disp_Command, i_Disp_Address,
        output o_Disp_Grant, o_Disp_Data_Read_Valid,
        output o_Command, o_Data_Address, o_Data_Write,
        input  i_Data_Read_Valid, i_Data_Write_Done,
        output o_Yield_Timeout, o_Max_Yield_Latency
    );

    modport master (
        output i_Proc_Command, i_Proc_Address, i_Proc_Data_Write, i_Proc_SDRAM_Yield,
        input  o_Proc_SDRAM_Requested, o_Proc_Data_Read_Valid, o_Proc_Data_Write_Done,
        output i_Disp_Request, i_Disp_Command, i_Disp_Address,
        input  o_Disp_Grant, o_Disp_Data_Read_Valid,
        input  o_Command, o_Data_Address, o_Data_Write,
        output i_Data_Read_Valid, i_Data_Write_Done,
        input  o_Yield_Timeout, o_Max_Yield_Latency
    );

endinterface

// File: rtl/sdram_client_mux.sv
// Combinational owner select: command/address/write-data toward the controller and
// read-valid / write-done steering back to whichever client owns the bus.
module sdram_client_mux
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_Reset,
    input  logic                  i_Disp_Owner,
    input  logic [1:0]            i_Proc_Command,
    input  logic [ADDR_WIDTH-1:0] i_Proc_Address,
    input  logic [DATA_WIDTH-1:0] i_Proc_Data_Write,
    input  logic [1:0]            i_Disp_Command,
    input  logic [ADDR_WIDTH-1:0] i_Disp_Address,
    input  logic                  i_Data_Read_Valid,
    input  logic                  i_Data_Write_Done,
    output logic [1:0]            o_Command,
    output logic [ADDR_WIDTH-1:0] o_Data_Address,
    output logic [DATA_WIDTH-1:0] o_Data_Write,
    output logic                  o_Proc_Data_Read_Valid,
    output logic                  o_Proc_Data_Write_Done,
    output logic                  o_Disp_Data_Read_Valid
);

    // Forward the owner's request; the display is read-only so its write data is zero.
    always_comb begin
        o_Command      = i_Proc_Command;
        o_Data_Address = i_Proc_Address;
        o_Data_Write   = i_Proc_Data_Write;
        if (i_Disp_Owner) begin
            o_Command      = i_Disp_Command;
            o_Data_Address = i_Disp_Address;
            o_Data_Write   = '0;
        end
        if (i_Reset) begin
            o_Command = CMD_IDLE;
        end
    end

    // Strobes reach only the owner; a display write-done has no consumer and is dropped.
    always_comb begin
        o_Proc_Data_Read_Valid = i_Data_Read_Valid & ~i_Disp_Owner;
        o_Proc_Data_Write_Done = i_Data_Write_Done & ~i_Disp_Owner;
        o_Disp_Data_Read_Valid = i_Data_Read_Valid &  i_Disp_Owner;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM arbiter: display fetcher takes the bus only once the processor
// yields, so a processor burst is never cut short. Tracks worst yield latency.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 22,
    parameter int DATA_WIDTH    = 32,
    parameter int YIELD_TIMEOUT = 255,
    parameter int LAT_WIDTH     = 8
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    sdram_arbiter_if.slave  bus
);

    owner_e               state_q, state_d;
    logic                 disp_grant_q;
    logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_WIDTH-1:0] max_lat_q, max_lat_d;
    logic                 yield_timeout_q, yield_timeout_d;
    logic                 waiting;

    localparam logic [LAT_WIDTH-1:0] TIMEOUT_CNT = LAT_WIDTH'(YIELD_TIMEOUT);

    // Display is waiting on the processor while it requests but does not yet own.
    assign waiting = (state_q == S_PROC) && bus.i_Disp_Request;

    // Owner next-state: hand over only on yield, hand back only once display is idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PROC: if (bus.i_Disp_Request && bus.i_Proc_SDRAM_Yield) state_d = S_DISP;
            S_DISP: if (!bus.i_Disp_Request && bus.i_Disp_Command == CMD_IDLE) state_d = S_PROC;
            default: state_d = S_PROC;
        endcase
    end

    // Yield statistics: saturating wait counter, running maximum and sticky timeout.
    always_comb begin
        lat_cnt_d = '0;
        if (waiting) begin
            lat_cnt_d = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + 1'b1;
        end

        max_lat_d = max_lat_q;
        if (state_q == S_PROC && state_d == S_DISP && lat_cnt_q > max_lat_q) begin
            max_lat_d = lat_cnt_q;
        end

        // Flag appears in the same cycle the registered counter shows the timeout value.
        yield_timeout_d = yield_timeout_q | (waiting && lat_cnt_d == TIMEOUT_CNT);
    end

    // Owner FSM with registered grant.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= S_PROC;
            disp_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_grant_q <= (state_d == S_DISP);
        end
    end

    // Statistics registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            lat_cnt_q       <= '0;
            max_lat_q       <= '0;
            yield_timeout_q <= 1'b0;
        end else begin
            lat_cnt_q       <= lat_cnt_d;
            max_lat_q       <= max_lat_d;
            yield_timeout_q <= yield_timeout_d;
        end
    end

    sdram_client_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_client_mux (
        .i_Reset                (i_Reset),
        .i_Disp_Owner           (state_q == S_DISP),
        .i_Proc_Command         (bus.i_Proc_Command),
        .i_Proc_Address         (bus.i_Proc_Address),
        .i_Proc_Data_Write      (bus.i_Proc_Data_Write),
        .i_Disp_Command         (bus.i_Disp_Command),
        .i_Disp_Address         (bus.i_Disp_Address),
        .i_Data_Read_Valid      (bus.i_Data_Read_Valid),
        .i_Data_Write_Done      (bus.i_Data_Write_Done),
        .o_Command              (bus.o_Command),
        .o_Data_Address         (bus.o_Data_Address),
        .o_Data_Write           (bus.o_Data_Write),
        .o_Proc_Data_Read_Valid (bus.o_Proc_Data_Read_Valid),
        .o_Proc_Data_Write_Done (bus.o_Proc_Data_Write_Done),
        .o_Disp_Data_Read_Valid (bus.o_Disp_Data_Read_Valid)
    );

    // Combinational so the processor sees the request in the very cycle it is raised.
    assign bus.o_Proc_SDRAM_Requested = bus.i_Disp_Request || (state_q == S_DISP);
    assign bus.o_Disp_Grant           = disp_grant_q;
    assign bus.o_Yield_Timeout        = yield_timeout_q;
    assign bus.o_Max_Yield_Latency    = max_lat_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: burst routing, yield handover, release, timeout, reset.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sdram_arbiter_if #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .LAT_WIDTH(8)) bus ();

    sdram_arbiter #(
        .ADDR_WIDTH    (22),
        .DATA_WIDTH    (32),
        .YIELD_TIMEOUT (255),
        .LAT_WIDTH     (8)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.i_Proc_Command     = CMD_READ;
        bus.i_Proc_Address     = 22'h000010;
        bus.i_Proc_Data_Write  = 32'hDEADBEEF;
        bus.i_Proc_SDRAM_Yield = 1'b0;
        bus.i_Disp_Request     = 1'b0;
        bus.i_Disp_Command     = CMD_IDLE;
        bus.i_Disp_Address     = 22'h003000;
        bus.i_Data_Read_Valid  = 1'b0;
        bus.i_Data_Write_Done  = 1'b0;

        // Reset state, command forced idle while reset is high.
        cyc(); cyc(); #1;
        chk("rst_cmd_idle", 32'(bus.o_Command), 32'(CMD_IDLE));
        chk("rst_grant", 32'(bus.o_Disp_Grant), 32'd0);
        chk("rst_max", 32'(bus.o_Max_Yield_Latency), 32'd0);
        chk("rst_timeout", 32'(bus.o_Yield_Timeout), 32'd0);

        // Test 1: processor read burst, beats go to processor only.
        cyc(); rst = 1'b0; #1;
        chk("t1_cmd", 32'(bus.o_Command), 32'(CMD_READ));
        chk("t1_addr", 32'(bus.o_Data_Address), 32'h10);
        chk("t1_wdata", bus.o_Data_Write, 32'hDEADBEEF);
        cyc(); bus.i_Proc_Command = CMD_IDLE;
        for (int b = 1; b <= READ_BURST_LENGTH; b++) begin
            cyc(); bus.i_Data_Read_Valid = 1'b1; #1;
            chk($sformatf("t1_pvalid_b%0d", b), 32'(bus.o_Proc_Data_Read_Valid), 32'd1);
            chk($sformatf("t1_dvalid_b%0d", b), 32'(bus.o_Disp_Data_Read_Valid), 32'd0);
        end
        cyc(); bus.i_Data_Read_Valid = 1'b0; bus.i_Data_Write_Done = 1'b1; #1;
        chk("t1_pwdone", 32'(bus.o_Proc_Data_Write_Done), 32'd1);
        cyc(); bus.i_Data_Write_Done = 1'b0;

        // Test 3: request with immediate yield records zero latency.
        cyc(); bus.i_Disp_Request = 1'b1; bus.i_Proc_SDRAM_Yield = 1'b1; #1;
        chk("t3_grant_pre", 32'(bus.o_Disp_Grant), 32'd0);
        chk("t3_requested", 32'(bus.o_Proc_SDRAM_Requested), 32'd1);
        cyc(); bus.i_Proc_SDRAM_Yield = 1'b0; #1;
        chk("t3_grant", 32'(bus.o_Disp_Grant), 32'd1);
        chk("t3_max", 32'(bus.o_Max_Yield_Latency), 32'd0);
        cyc(); bus.i_Disp_Request = 1'b0; #1;
        chk("t3_req_held", 32'(bus.o_Proc_SDRAM_Requested), 32'd1);
        cyc(); #1;
        chk("t3_released", 32'(bus.o_Disp_Grant), 32'd0);
        chk("t3_req_low", 32'(bus.o_Proc_SDRAM_Requested), 32'd0);

        // Test 2: request arrives on beat 3 of a processor burst; waits 6 cycles.
        cyc(); bus.i_Proc_Command = CMD_READ; bus.i_Proc_Address = 22'h000040; #1;
        chk("t2_cmd", 32'(bus.o_Command), 32'(CMD_READ));
        cyc(); bus.i_Proc_Command = CMD_IDLE;
        for (int b = 1; b <= READ_BURST_LENGTH; b++) begin
            cyc(); bus.i_Data_Read_Valid = 1'b1;
            if (b == 3) bus.i_Disp_Request = 1'b1;
            #1;
            chk($sformatf("t2_pvalid_b%0d", b), 32'(bus.o_Proc_Data_Read_Valid), 32'd1);
            chk($sformatf("t2_dvalid_b%0d", b), 32'(bus.o_Disp_Data_Read_Valid), 32'd0);
        end
        cyc(); bus.i_Data_Read_Valid = 1'b0; bus.i_Proc_SDRAM_Yield = 1'b1; #1;
        chk("t2_grant_pre", 32'(bus.o_Disp_Grant), 32'd0);
        cyc(); bus.i_Proc_SDRAM_Yield = 1'b0; #1;
        chk("t2_grant", 32'(bus.o_Disp_Grant), 32'd1);
        chk("t2_max", 32'(bus.o_Max_Yield_Latency), 32'd6);

        // Test 4: display traffic routing, then request dropped with READ still active.
        cyc(); bus.i_Disp_Command = CMD_READ; #1;
        chk("t4_cmd", 32'(bus.o_Command), 32'(CMD_READ));
        chk("t4_addr", 32'(bus.o_Data_Address), 32'h3000);
        chk("t4_wdata", bus.o_Data_Write, 32'd0);
        cyc(); bus.i_Data_Read_Valid = 1'b1; bus.i_Data_Write_Done = 1'b1;
        bus.i_Disp_Request = 1'b0; #1;
        chk("t4_dvalid", 32'(bus.o_Disp_Data_Read_Valid), 32'd1);
        chk("t4_pvalid", 32'(bus.o_Proc_Data_Read_Valid), 32'd0);
        chk("t4_pwdone", 32'(bus.o_Proc_Data_Write_Done), 32'd0);
        cyc(); bus.i_Data_Read_Valid = 1'b0; bus.i_Data_Write_Done = 1'b0;
        bus.i_Disp_Command = CMD_WRITE; #1;
        chk("t4_stay_grant", 32'(bus.o_Disp_Grant), 32'd1);
        chk("t4_stay_req", 32'(bus.o_Proc_SDRAM_Requested), 32'd1);
        chk("t4_disp_write", 32'(bus.o_Command), 32'(CMD_WRITE));
        cyc(); bus.i_Disp_Command = CMD_IDLE; #1;
        chk("t4_still_grant", 32'(bus.o_Disp_Grant), 32'd1);
        cyc(); #1;
        chk("t4_released", 32'(bus.o_Disp_Grant), 32'd0);
        chk("t4_req_low", 32'(bus.o_Proc_SDRAM_Requested), 32'd0);
        chk("t4_cmd_proc", 32'(bus.o_Command), 32'(CMD_IDLE));

        // Test 5: processor withholds yield for 300 cycles.
        cyc(); bus.i_Disp_Request = 1'b1;
        for (int j = 0; j < 300; j++) begin
            if (j > 0) cyc();
            #1;
            if (j == 254) chk("t5_timeout_pre", 32'(bus.o_Yield_Timeout), 32'd0);
            if (j == 255) chk("t5_timeout_set", 32'(bus.o_Yield_Timeout), 32'd1);
            if (j == 299) chk("t5_no_grant", 32'(bus.o_Disp_Grant), 32'd0);
        end
        cyc(); bus.i_Proc_SDRAM_Yield = 1'b1;
        cyc(); bus.i_Proc_SDRAM_Yield = 1'b0; #1;
        chk("t5_grant", 32'(bus.o_Disp_Grant), 32'd1);
        chk("t5_max", 32'(bus.o_Max_Yield_Latency), 32'd255);
        chk("t5_timeout_sticky", 32'(bus.o_Yield_Timeout), 32'd1);

        // Test 6: reset while display owns the bus.
        cyc(); rst = 1'b1; bus.i_Proc_Command = CMD_READ; bus.i_Disp_Command = CMD_READ; #1;
        chk("t6_cmd_forced", 32'(bus.o_Command), 32'(CMD_IDLE));
        cyc(); #1;
        chk("t6_grant", 32'(bus.o_Disp_Grant), 32'd0);
        chk("t6_max", 32'(bus.o_Max_Yield_Latency), 32'd0);
        chk("t6_timeout", 32'(bus.o_Yield_Timeout), 32'd0);
        cyc(); rst = 1'b0; bus.i_Disp_Request = 1'b0; bus.i_Disp_Command = CMD_IDLE; #1;
        chk("t6_proc_owner", 32'(bus.o_Command), 32'(CMD_READ));
        chk("t6_proc_addr", 32'(bus.o_Data_Address), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
